// File: rtl/apb_mst_arb_pkg.sv
// Shared definitions for the two-master APB arbiter: FSM states, slot decode
// field position, slot count and small decode helpers.
package apb_mst_arb_pkg;

    localparam int unsigned ADDR_W   = 40;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned SLOT_HI  = 14;
    localparam int unsigned SLOT_LO  = 12;
    localparam int unsigned SLOT_CNT = 7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_ERR    = 2'd3
    } apb_state_e;

    // Slot number carried in the address; slot 0 has no slave behind it.
    function automatic logic [2:0] addr_slot(input logic [ADDR_W-1:0] addr);
        return addr[SLOT_HI:SLOT_LO];
    endfunction

    // Pick the read-data lane of a mapped slot out of the packed bus.
    function automatic logic [DATA_W-1:0] slot_rdata(
        input logic [SLOT_CNT*DATA_W-1:0] bus,
        input logic [2:0]                 slot
    );
        logic [DATA_W-1:0] r;
        r = '0;
        for (int unsigned i = 1; i <= SLOT_CNT; i++) begin
            if (slot == 3'(i)) begin
                r = bus[DATA_W*(i-1) +: DATA_W];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/apb_mst_arb_rr.sv
// Two-input round-robin grant with a one-bit last-served pointer.
module apb_mst_rr
    import apb_mst_arb_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic req0_i,
    input  logic req1_i,
    input  logic upd_i,
    input  logic upd_idx_i,
    output logic gnt_vld_o,
    output logic gnt_idx_o
);

    logic last_q;
    logic last_d;

    // Grant: on a tie favour the master not served last, else the lone requester.
    always_comb begin
        gnt_vld_o = req0_i | req1_i;
        if (req0_i && req1_i) begin
            gnt_idx_o = ~last_q;
        end else begin
            gnt_idx_o = req1_i;
        end
        last_d = upd_i ? upd_idx_i : last_q;
    end

    // Pointer moves only when a transfer completes; reset favours m0 first.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/apb_mst_arb.sv
// Two-master APB bridge: round-robin arbitration, 3-bit slot decode onto a
// 7-slave one-hot select, configurable ACCESS wait states and error reply
// for the unmapped slot.
module apb_mst_arb
    import apb_mst_arb_pkg::*;
#(
    parameter int unsigned WAIT_CYC = 0
) (
    input  logic          per_clk,
    input  logic          per_rst,
    input  logic          m0_req,
    input  logic          m1_req,
    input  logic [39:0]   m0_addr,
    input  logic [39:0]   m1_addr,
    input  logic          m0_write,
    input  logic          m1_write,
    input  logic [31:0]   m0_wdata,
    input  logic [31:0]   m1_wdata,
    output logic          m0_done,
    output logic          m1_done,
    output logic          m0_err,
    output logic          m1_err,
    output logic [31:0]   m0_rdata,
    output logic [31:0]   m1_rdata,
    output logic [39:0]   apb_xx_paddr,
    output logic          apb_xx_pwrite,
    output logic [31:0]   apb_xx_pwdata,
    output logic          apb_xx_penable,
    output logic [6:0]    psel,
    input  logic [223:0]  prdata_bus
);

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYC);

    apb_state_e  state_q;
    logic        gnt_q;
    logic [2:0]  slot_q;
    logic [39:0] cmd_addr_q;
    logic        cmd_write_q;
    logic [31:0] cmd_wdata_q;
    logic [6:0]  psel_q;
    logic        penable_q;
    logic        done_q;
    logic        err_q;
    logic [3:0]  cnt_q;
    logic [31:0] m0_rdata_q;
    logic [31:0] m1_rdata_q;

    logic        gnt_vld;
    logic        gnt_idx;
    logic [39:0] win_addr;
    logic        win_write;
    logic [31:0] win_wdata;
    logic [2:0]  win_slot;
    logic [31:0] cur_rdata;

    apb_mst_rr u_rr (
        .clk_i     (per_clk),
        .rst_i     (per_rst),
        .req0_i    (m0_req),
        .req1_i    (m1_req),
        .upd_i     (done_q),
        .upd_idx_i (gnt_q),
        .gnt_vld_o (gnt_vld),
        .gnt_idx_o (gnt_idx)
    );

    // Winner's command and decoded slot, plus the data returned on completion.
    always_comb begin
        win_addr  = gnt_idx ? m1_addr  : m0_addr;
        win_write = gnt_idx ? m1_write : m0_write;
        win_wdata = gnt_idx ? m1_wdata : m0_wdata;
        win_slot  = addr_slot(win_addr);
        if (err_q || cmd_write_q) begin
            cur_rdata = '0;
        end else begin
            cur_rdata = slot_rdata(prdata_bus, slot_q);
        end
    end

    // Transfer FSM; done is registered one cycle early so it lines up with the
    // final ACCESS cycle, while read data is taken live from the bus that cycle.
    always_ff @(posedge per_clk or posedge per_rst) begin
        if (per_rst) begin
            state_q     <= ST_IDLE;
            gnt_q       <= 1'b0;
            slot_q      <= '0;
            cmd_addr_q  <= '0;
            cmd_write_q <= 1'b0;
            cmd_wdata_q <= '0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (gnt_vld) begin
                        gnt_q       <= gnt_idx;
                        slot_q      <= win_slot;
                        cmd_addr_q  <= win_addr;
                        cmd_write_q <= win_write;
                        cmd_wdata_q <= win_wdata;
                        if (win_slot == 3'd0) begin
                            state_q <= ST_ERR;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else begin
                            state_q <= ST_SETUP;
                            psel_q  <= 7'b1 << (win_slot - 3'd1);
                        end
                    end
                end
                ST_SETUP: begin
                    state_q   <= ST_ACCESS;
                    penable_q <= 1'b1;
                    cnt_q     <= '0;
                    done_q    <= (WAIT_LAST == 4'd0);
                end
                ST_ACCESS: begin
                    if (cnt_q == WAIT_LAST) begin
                        state_q   <= ST_IDLE;
                        psel_q    <= '0;
                        penable_q <= 1'b0;
                        done_q    <= 1'b0;
                        cnt_q     <= '0;
                    end else begin
                        cnt_q  <= cnt_q + 4'd1;
                        done_q <= ((cnt_q + 4'd1) == WAIT_LAST);
                    end
                end
                ST_ERR: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Hold each master's last returned data between its completions.
    always_ff @(posedge per_clk or posedge per_rst) begin
        if (per_rst) begin
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else if (done_q) begin
            if (gnt_q) begin
                m1_rdata_q <= cur_rdata;
            end else begin
                m0_rdata_q <= cur_rdata;
            end
        end
    end

    assign m0_done        = done_q & ~gnt_q;
    assign m1_done        = done_q &  gnt_q;
    assign m0_err         = err_q  & ~gnt_q;
    assign m1_err         = err_q  &  gnt_q;
    assign m0_rdata       = m0_done ? cur_rdata : m0_rdata_q;
    assign m1_rdata       = m1_done ? cur_rdata : m1_rdata_q;
    assign apb_xx_paddr   = cmd_addr_q;
    assign apb_xx_pwrite  = cmd_write_q;
    assign apb_xx_pwdata  = cmd_wdata_q;
    assign apb_xx_penable = penable_q;
    assign psel           = psel_q;

endmodule
